router_fifo: RTL and testbench

- Per-destination output FIFO of the 1x3 router. Three instances sit directly downstream of the router register stage.
- Stores bytes from the register stage's dout, tagging each stored word with a header flag.
- On the read side, tracks the remaining packet length so the output is cleared at packet end.
- Supports a synchronous soft reset, driven by the synchroniser's 30-cycle read timeout.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_fifo_mem.sv | 52 +++++
 rtl/router_fifo.sv | 96 +++++++++
 tb/tb_router_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths, header-length field position and stored-word layout for the router.
package router_pkg;

  localparam int unsigned ROUTER_DWIDTH = 8;
  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned FIFO_AWIDTH   = 4;
  localparam int unsigned HDR_LEN_MSB   = 7;
  localparam int unsigned HDR_LEN_LSB   = 2;

  typedef struct packed {
    logic                     hdr;
    logic [ROUTER_DWIDTH-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Register array with one write port and one registered read port.
// Also exposes the header flag and length field of the word at the read address.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned DWIDTH = ROUTER_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_AWIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_clr,
  input  logic                                i_we,
  input  logic [AWIDTH-1:0]                   i_waddr,
  input  logic [DWIDTH:0]                     i_wdata,
  input  logic                                i_re,
  input  logic                                i_zero,
  input  logic [AWIDTH-1:0]                   i_raddr,
  output logic                                o_peek_hdr,
  output logic [HDR_LEN_MSB-HDR_LEN_LSB:0]    o_peek_len,
  output logic [DWIDTH-1:0]                   o_rdata
);

  logic [DWIDTH:0]   r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;
  logic [DWIDTH:0]   w_peek;

  assign w_peek     = r_mem[i_raddr];
  assign o_peek_hdr = w_peek[DWIDTH];
  assign o_peek_len = w_peek[HDR_LEN_MSB:HDR_LEN_LSB];
  assign o_rdata    = r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // i_zero clears the output between packets once the length count has run out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_peek[DWIDTH-1:0];
    end else if (i_zero) begin
      r_rdata <= '0;
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: tags stored bytes with a header
// flag and tracks remaining packet length on the read side.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned DWIDTH = ROUTER_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_AWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] data_out
);

  localparam int unsigned LENW = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  logic [AWIDTH:0]   r_wr_ptr;
  logic [AWIDTH:0]   r_rd_ptr;
  logic [6:0]        r_count;
  logic              r_lfd_q;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_zero;
  logic              w_peek_hdr;
  logic [LENW-1:0]   w_peek_len;
  logic [AWIDTH:0]   w_ptr_one;

  assign w_ptr_one = {{AWIDTH{1'b0}}, 1'b1};
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]) &&
                     (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]);
  assign w_wr      = write_enb && !w_full;
  assign w_rd      = read_enb && !w_empty;
  assign w_zero    = !w_rd && (r_count == '0);

  assign full  = w_full;
  assign empty = w_empty;

  router_fifo_mem #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk        (clock),
    .rst        (reset),
    .i_clr      (soft_reset),
    .i_we       (w_wr && !soft_reset),
    .i_waddr    (r_wr_ptr[AWIDTH-1:0]),
    .i_wdata    ({r_lfd_q, data_in}),
    .i_re       (w_rd),
    .i_zero     (w_zero),
    .i_raddr    (r_rd_ptr[AWIDTH-1:0]),
    .o_peek_hdr (w_peek_hdr),
    .o_peek_len (w_peek_len),
    .o_rdata    (data_out)
  );

  // Header reaches data_in one cycle after lfd_state, so the stored flag is the delayed copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lfd_q  <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lfd_q  <= 1'b0;
    end else begin
      r_lfd_q <= lfd_state;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + w_ptr_one;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + w_ptr_one;
        if (w_peek_hdr) begin
          r_count <= 7'({1'b0, w_peek_len}) + 7'd1;
        end else if (r_count != '0) begin
          r_count <= r_count - 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: stimulus queues expected data_out per cycle,
// a monitor process pops and compares after each clock edge.
module tb_router_fifo;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  always #5 clock = ~clock;

  router_fifo #(
    .DEPTH  (16),
    .DWIDTH (8),
    .AWIDTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
  );

  int errors = 0;
  int checks = 0;

  fifo_word_t  mq[$];
  logic        m_lfd;
  logic [6:0]  m_cnt;
  logic [7:0]  m_dout;
  int unsigned m_wr;
  logic [7:0]  exp_q[$];
  logic        take = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_lfd  = 1'b0;
    m_cnt  = '0;
    m_dout = '0;
    m_wr   = 0;
  endtask

  // One clock of stimulus; the reference model advances and queues the expected output.
  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic srst = 1'b0);
    logic       rd_ok;
    logic       wr_ok;
    fifo_word_t w;
    @(negedge clock);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    if (srst) begin
      model_clear();
    end else begin
      rd_ok = re && (mq.size() != 0);
      wr_ok = we && (mq.size() != 16);
      if (rd_ok) begin
        w      = mq.pop_front();
        m_dout = w.data;
        if (w.hdr) m_cnt = 7'({1'b0, w.data[7:2]}) + 7'd1;
        else if (m_cnt != 0) m_cnt = m_cnt - 7'd1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr_ok) begin
        w.hdr  = m_lfd;
        w.data = din;
        mq.push_back(w);
        m_wr++;
      end
      m_lfd = lfd;
    end
    exp_q.push_back(m_dout);
    take = 1'b1;
    @(posedge clock);
    #1;
    chk("full", full, (mq.size() == 16) ? 1 : 0);
    chk("empty", empty, (mq.size() == 0) ? 1 : 0);
    chk("count", dut.r_count, m_cnt);
    take = 1'b0;
  endtask

  initial begin : monitor
    logic       t;
    logic [7:0] e;
    forever begin
      @(posedge clock);
      t = take;
      #1;
      if (t) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned base;
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    model_clear();
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_count", dut.r_count, 0);
    @(negedge clock);
    reset = 1'b0;

    // Fill to full, overflow drop, drain in order
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    chk("full_after_16", full, 1);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("full_after_drop", full, 1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_order", data_out, i);
    end
    chk("empty_after_drain", empty, 1);

    // Header alignment and packet counter
    base = m_wr % 16;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h0D);
    step(1'b1, 1'b0, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 1'b0, 8'hA3);
    step(1'b1, 1'b0, 1'b0, 8'h5C);
    for (int k = 0; k < 5; k++)
      chk("stored_flag", dut.u_mem.r_mem[(base + k) % 16][8], (k == 0) ? 1 : 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("hdr_count", dut.r_count, 4);
    chk("hdr_dout", data_out, 8'h0D);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pkt_end_count", dut.r_count, 0);
    chk("last_payload", data_out, 8'h5C);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("idle_clear", data_out, 0);

    // Simultaneous read/write on empty
    step(1'b1, 1'b1, 1'b0, 8'h33);
    chk("empty_rw_notempty", empty, 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("empty_rw_data", data_out, 8'h33);

    // Simultaneous read/write on full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("full_rw_data", data_out, 8'h40);
    chk("full_rw_notfull", full, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("full_rw_last", data_out, 8'h4F);
    chk("full_rw_empty", empty, 1);

    // Interleaved traffic across the pointer wrap
    step(1'b1, 1'b0, 1'b0, 8'h80);
    for (int i = 1; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_last", data_out, 8'h93);

    // Soft reset mid-packet
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b1, 1'b0, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 1'b0, 8'hB2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("sr_hdr_count", dut.r_count, 5);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("sr_empty", empty, 1);
    chk("sr_full", full, 0);
    chk("sr_dout", data_out, 0);
    chk("sr_count", dut.r_count, 0);
    soft_reset = 1'b0;

    // Asynchronous reset mid-packet, between clock edges
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h20);
    step(1'b1, 1'b0, 1'b0, 8'hC2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ar_pre_count", dut.r_count, 9);
    write_enb = 1'b0;
    read_enb  = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_dout", data_out, 0);
    chk("ar_count", dut.r_count, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_reset_data", data_out, 8'h5A);

    @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
